// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types and constants for the instruction fetch queue
package ifq_pkg;

   localparam int IFQ_ADDR_W = 32;
   localparam int IFQ_DATA_W = 32;
   localparam int IFQ_DEPTH  = 4;
   localparam int IFQ_PTR_W  = $clog2(IFQ_DEPTH) + 1;

   // First PC fetched after reset; the PC stage starts from the same address.
   localparam logic [IFQ_ADDR_W-1:0] IFQ_RESET_ADDR = 32'h8000_0000;

   // One queue slot: misalign marks a fault entry that never went to memory.
   typedef struct packed {
      logic [IFQ_ADDR_W-1:0] pc;
      logic [IFQ_DATA_W-1:0] inst;
      logic                  filled;
      logic                  misalign;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_ptr.sv
// rtl/ifq_ptr.sv - wrap-bit queue pointer with clear and increment
module ifq_ptr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value
);

   // Clear wins over increment so a flush always lands the pointer on zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/ifq.sv
// rtl/ifq.sv - instruction fetch queue; define IFQ_MISALIGN_CHK_EN to turn misaligned PCs into fault entries
module ifq
   import ifq_pkg::*;
#(
   parameter int ADDR_WIDTH = IFQ_ADDR_W,
   parameter int DATA_WIDTH = IFQ_DATA_W,
   parameter int DEPTH      = IFQ_DEPTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   input  logic                  i_flush,
   output logic                  o_imem_req_valid,
   input  logic                  i_imem_req_ready,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   input  logic                  i_imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] i_imem_rsp_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [ADDR_WIDTH-1:0] o_pc,
   output logic [DATA_WIDTH-1:0] o_inst,
   output logic                  o_misalign
);

   localparam int PTR_W  = $clog2(DEPTH) + 1;
   localparam int IDX_W  = PTR_W - 1;
   localparam int DISC_W = $clog2(DEPTH + 1);

   ifq_entry_t          entries [DEPTH];
   logic [PTR_W-1:0]    alloc_ptr;
   logic [PTR_W-1:0]    fill_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    alloc;
   logic [PTR_W-1:0]    pending;
   logic [DISC_W-1:0]   discard_cnt;
   logic [DISC_W-1:0]   discard_nxt;
   logic [IDX_W-1:0]    alloc_idx;
   logic [IDX_W-1:0]    fill_idx;
   logic [IDX_W-1:0]    rd_idx;
   logic                space;
   logic                misal;
   logic                issue;
   logic                discarding;
   logic                rsp_take;
   logic                rsp_used;
   logic                fill_inc;
   logic                deq;
   ifq_entry_t          head;

   assign alloc     = alloc_ptr - rd_ptr;
   assign pending   = alloc_ptr - fill_ptr;
   assign space     = alloc < PTR_W'(DEPTH);
   assign alloc_idx = alloc_ptr[IDX_W-1:0];
   assign fill_idx  = fill_ptr[IDX_W-1:0];
   assign rd_idx    = rd_ptr[IDX_W-1:0];

`ifdef IFQ_MISALIGN_CHK_EN
   assign misal = i_pc[1:0] != 2'b00;
`else
   assign misal = 1'b0;
`endif

   // A misaligned PC bypasses memory, so it waits only for older fetches to
   // drain (keeps fill order equal to alloc order) and ignores memory ready.
   assign o_imem_req_valid = i_rst_n & i_valid & space & ~i_flush & ~misal;
   assign o_imem_addr      = i_pc;
   assign o_ready          = i_rst_n & space & ~i_flush &
                             (misal ? (pending == '0) : i_imem_req_ready);
   assign issue            = i_valid & o_ready;

   // Stale responses from before a flush are consumed first; a response with
   // nothing outstanding is ignored.
   assign discarding = i_imem_rsp_valid & (discard_cnt != '0);
   assign rsp_take   = i_imem_rsp_valid & (discard_cnt == '0) & (pending != '0);
   assign rsp_used   = discarding | rsp_take;
   assign fill_inc   = rsp_take | (issue & misal);

   assign head       = entries[rd_idx];
   assign o_valid    = (alloc != '0) & head.filled;
   assign o_pc       = ADDR_WIDTH'(head.pc);
   assign o_inst     = DATA_WIDTH'(head.inst);
   assign o_misalign = head.misalign;
   assign deq        = o_valid & i_ready;

   ifq_ptr #(.W(PTR_W)) u_alloc_ptr (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clr   (i_flush),
      .inc   (issue),
      .value (alloc_ptr)
   );

   ifq_ptr #(.W(PTR_W)) u_fill_ptr (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clr   (i_flush),
      .inc   (fill_inc),
      .value (fill_ptr)
   );

   ifq_ptr #(.W(PTR_W)) u_rd_ptr (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clr   (i_flush),
      .inc   (deq),
      .value (rd_ptr)
   );

   // On flush every in-flight request becomes a stale response to swallow,
   // less whatever response is consumed in the flush cycle itself.
   always_comb begin
      discard_nxt = discard_cnt;
      if (i_flush) begin
         discard_nxt = discard_cnt + DISC_W'(pending) - DISC_W'(rsp_used);
      end else if (discarding) begin
         discard_nxt = discard_cnt - DISC_W'(1);
      end
   end

   // Stale-response counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         discard_cnt <= '0;
      end else begin
         discard_cnt <= discard_nxt;
      end
   end

   // Entry storage: allocation writes the PC, responses fill in order; the two
   // never hit the same slot because a full queue blocks allocation.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (i_flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].filled <= 1'b0;
         end
      end else begin
         if (issue) begin
            entries[alloc_idx].pc       <= IFQ_ADDR_W'(i_pc);
            entries[alloc_idx].inst     <= '0;
            entries[alloc_idx].filled   <= misal;
            entries[alloc_idx].misalign <= misal;
         end
         if (rsp_take) begin
            entries[fill_idx].inst   <= IFQ_DATA_W'(i_imem_rsp_data);
            entries[fill_idx].filled <= 1'b1;
         end
      end
   end

   a_no_orphan_rsp : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(i_imem_rsp_valid && discard_cnt == '0 && pending == '0));

endmodule

// File: tb/tb_ifq.sv
// tb/tb_ifq.sv - directed self-checking bench for ifq
module tb_ifq;
   import ifq_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_pc;
   logic        i_flush;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [31:0] o_imem_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_misalign;

   int compared = 0;
   int mismatched = 0;

   ifq dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_valid          (i_valid),
      .o_ready          (o_ready),
      .i_pc             (i_pc),
      .i_flush          (i_flush),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_addr      (o_imem_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rsp_data  (i_imem_rsp_data),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_pc             (o_pc),
      .o_inst           (o_inst),
      .o_misalign       (o_misalign)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_pc = '0; i_flush = 1'b0;
      i_imem_req_ready = 1'b1; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0;
      i_ready = 1'b0;

      // reset state
      #12;
      i_valid = 1'b1;
      #1;
      chk1("rst_o_valid", o_valid, 1'b0);
      chk32("rst_o_pc", o_pc, 32'h0);
      chk32("rst_o_inst", o_inst, 32'h0);
      chk1("rst_o_misalign", o_misalign, 1'b0);
      chk1("rst_req_valid", o_imem_req_valid, 1'b0);
      i_valid = 1'b0;
      #1;
      i_rst_n = 1'b1;
      tick();

      // streaming fetch, one-cycle memory
      i_valid = 1'b1; i_pc = IFQ_RESET_ADDR;
      #1;
      chk1("t1_ready", o_ready, 1'b1);
      chk1("t1_req_valid", o_imem_req_valid, 1'b1);
      chk32("t1_addr", o_imem_addr, 32'h8000_0000);
      chk1("t1_c0_o_valid", o_valid, 1'b0);
      tick();
      i_pc = 32'h8000_0004; i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h13;
      #1;
      chk1("t1_c1_o_valid", o_valid, 1'b0);
      tick();
      i_pc = 32'h8000_0008; i_imem_rsp_data = 32'h93; i_ready = 1'b1;
      #1;
      chk1("t1_c2_o_valid", o_valid, 1'b1);
      chk32("t1_c2_pc", o_pc, 32'h8000_0000);
      chk32("t1_c2_inst", o_inst, 32'h13);
      tick();
      i_valid = 1'b0; i_imem_rsp_data = 32'h113;
      #1;
      chk1("t1_c3_o_valid", o_valid, 1'b1);
      chk32("t1_c3_pc", o_pc, 32'h8000_0004);
      chk32("t1_c3_inst", o_inst, 32'h93);
      tick();
      i_imem_rsp_valid = 1'b0;
      #1;
      chk1("t1_c4_o_valid", o_valid, 1'b1);
      chk32("t1_c4_pc", o_pc, 32'h8000_0008);
      chk32("t1_c4_inst", o_inst, 32'h113);
      tick();
      i_ready = 1'b0;
      #1;
      chk1("t1_c5_o_valid", o_valid, 1'b0);

      // full queue with decode stalled, then drain (pointers wrap here)
      i_valid = 1'b1; i_pc = 32'h100;
      tick();
      i_pc = 32'h104; i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h1001;
      tick();
      i_pc = 32'h108; i_imem_rsp_data = 32'h1002;
      tick();
      i_pc = 32'h10c; i_imem_rsp_data = 32'h1003;
      #1;
      chk1("t2_c3_ready", o_ready, 1'b1);
      tick();
      i_pc = 32'h110; i_imem_rsp_data = 32'h1004;
      #1;
      chk1("t2_full_ready", o_ready, 1'b0);
      chk1("t2_full_req_valid", o_imem_req_valid, 1'b0);
      tick();
      i_imem_rsp_valid = 1'b0; i_ready = 1'b1;
      #1;
      chk1("t2_deq_same_cycle_ready", o_ready, 1'b0);
      chk32("t2_c5_pc", o_pc, 32'h100);
      chk32("t2_c5_inst", o_inst, 32'h1001);
      tick();
      #1;
      chk1("t2_c6_ready", o_ready, 1'b1);
      chk1("t2_c6_req_valid", o_imem_req_valid, 1'b1);
      chk32("t2_c6_addr", o_imem_addr, 32'h110);
      chk32("t2_c6_pc", o_pc, 32'h104);
      chk32("t2_c6_inst", o_inst, 32'h1002);
      tick();
      i_valid = 1'b0; i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h1005;
      #1;
      chk32("t2_c7_pc", o_pc, 32'h108);
      tick();
      i_imem_rsp_valid = 1'b0;
      #1;
      chk32("t2_c8_pc", o_pc, 32'h10c);
      chk32("t2_c8_inst", o_inst, 32'h1004);
      tick();
      #1;
      chk1("t2_c9_o_valid", o_valid, 1'b1);
      chk32("t2_c9_pc", o_pc, 32'h110);
      chk32("t2_c9_inst", o_inst, 32'h1005);
      tick();
      i_ready = 1'b0;
      #1;
      chk1("t2_c10_o_valid", o_valid, 1'b0);

      // flush with two slow requests outstanding
      i_valid = 1'b1; i_pc = 32'h200;
      tick();
      i_pc = 32'h204;
      tick();
      i_pc = 32'h208; i_flush = 1'b1;
      #1;
      chk1("t3_flush_ready", o_ready, 1'b0);
      chk1("t3_flush_req_valid", o_imem_req_valid, 1'b0);
      tick();
      i_flush = 1'b0; i_pc = 32'h8000_0100;
      i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'hdead_0001;
      #1;
      chk32("t3_discard_2", 32'(dut.discard_cnt), 32'd2);
      chk1("t3_ready_during_discard", o_ready, 1'b1);
      tick();
      i_valid = 1'b0; i_imem_rsp_data = 32'hdead_0002;
      #1;
      chk32("t3_discard_1", 32'(dut.discard_cnt), 32'd1);
      chk1("t3_c4_o_valid", o_valid, 1'b0);
      tick();
      i_imem_rsp_data = 32'h0050_0093;
      #1;
      chk32("t3_discard_0", 32'(dut.discard_cnt), 32'd0);
      chk1("t3_c5_o_valid", o_valid, 1'b0);
      tick();
      i_imem_rsp_valid = 1'b0; i_ready = 1'b1;
      #1;
      chk1("t3_c6_o_valid", o_valid, 1'b1);
      chk32("t3_c6_pc", o_pc, 32'h8000_0100);
      chk32("t3_c6_inst", o_inst, 32'h0050_0093);
      tick();
      i_ready = 1'b0;
      #1;
      chk1("t3_c7_o_valid", o_valid, 1'b0);

      // flush colliding with a response and a dequeue
      i_valid = 1'b1; i_pc = 32'h300;
      tick();
      i_pc = 32'h304; i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h11;
      tick();
      i_pc = 32'h308; i_imem_rsp_valid = 1'b0;
      #1;
      chk1("t4_c2_o_valid", o_valid, 1'b1);
      chk32("t4_c2_pc", o_pc, 32'h300);
      tick();
      i_valid = 1'b0; i_flush = 1'b1; i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data = 32'h22; i_ready = 1'b1;
      tick();
      i_flush = 1'b0; i_ready = 1'b0; i_imem_rsp_data = 32'h33;
      #1;
      chk1("t4_empty_o_valid", o_valid, 1'b0);
      chk32("t4_discard", 32'(dut.discard_cnt), 32'd1);
      chk1("t4_empty_ready", o_ready, 1'b1);
      tick();
      i_imem_rsp_valid = 1'b0;
      #1;
      chk32("t4_discard_drained", 32'(dut.discard_cnt), 32'd0);
      chk1("t4_c5_o_valid", o_valid, 1'b0);

      // asynchronous reset mid-stream
      i_valid = 1'b1; i_pc = 32'h400;
      tick();
      i_pc = 32'h404; i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h44;
      tick();
      i_pc = 32'h408; i_imem_rsp_valid = 1'b0;
      tick();
      i_valid = 1'b0;
      #1;
      chk1("t5_pre_o_valid", o_valid, 1'b1);
      chk32("t5_pre_pc", o_pc, 32'h400);
      i_valid = 1'b1; i_rst_n = 1'b0;
      #1;
      chk1("t5_rst_o_valid", o_valid, 1'b0);
      chk32("t5_rst_pc", o_pc, 32'h0);
      chk32("t5_rst_inst", o_inst, 32'h0);
      chk1("t5_rst_req_valid", o_imem_req_valid, 1'b0);
      chk1("t5_rst_ready", o_ready, 1'b0);
      i_valid = 1'b0;
      #1;
      i_rst_n = 1'b1;
      tick();
      #1;
      chk1("t5_post_o_valid", o_valid, 1'b0);
      chk32("t5_post_discard", 32'(dut.discard_cnt), 32'd0);
      chk32("t5_post_alloc", 32'(dut.alloc), 32'd0);
      chk1("t5_post_ready", o_ready, 1'b1);

      // misaligned PC
`ifdef IFQ_MISALIGN_CHK_EN
      i_valid = 1'b1; i_pc = 32'h8000_0002; i_imem_req_ready = 1'b0;
      #1;
      chk1("t6_req_valid", o_imem_req_valid, 1'b0);
      chk1("t6_ready", o_ready, 1'b1);
      tick();
      i_valid = 1'b0; i_imem_req_ready = 1'b1; i_ready = 1'b1;
      #1;
      chk1("t6_o_valid", o_valid, 1'b1);
      chk1("t6_misalign", o_misalign, 1'b1);
      chk32("t6_inst", o_inst, 32'h0);
      chk32("t6_pc", o_pc, 32'h8000_0002);
      tick();
`else
      i_valid = 1'b1; i_pc = 32'h8000_0002;
      #1;
      chk1("t6_req_valid", o_imem_req_valid, 1'b1);
      chk32("t6_addr", o_imem_addr, 32'h8000_0002);
      tick();
      i_valid = 1'b0; i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h77;
      tick();
      i_imem_rsp_valid = 1'b0; i_ready = 1'b1;
      #1;
      chk1("t6_o_valid", o_valid, 1'b1);
      chk1("t6_misalign", o_misalign, 1'b0);
      chk32("t6_inst", o_inst, 32'h77);
      chk32("t6_pc", o_pc, 32'h8000_0002);
      tick();
`endif
      i_ready = 1'b0;
      #1;
      chk1("t6_drained", o_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
